muldiv_unit: RTL and testbench

Iterative multiply/divide unit implementing the eight RV32M operations for a parametrised datapath width. It sits beside the single-cycle `alu` in the CPU execute stage and handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. Its variable-latency valid/ready handshake lets the core stall while an operation is in flight. It computes one result bit per cycle: radix-2 shift-add for multiply and restoring division for divide.

---
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one result bit per cycle.
// Radix-2 shift-add multiply, restoring divide, valid/ready handshake.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] res_q;
    logic [2:0]      op_q;
    logic            neg_q;
    logic            neg_r;

    logic            accept;
    logic            is_div;
    logic            a_sgn;
    logic            b_sgn;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] spec_res;

    logic            last;
    logic [XLEN:0]   sum;
    logic [XLEN-1:0] mul_hi;
    logic [XLEN-1:0] mul_lo;
    logic [XLEN:0]   diff;
    logic            fits;
    logic [XLEN-1:0] div_hi;
    logic [XLEN-1:0] div_lo;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] fin;

    assign accept = start_valid && (state == IDLE);
    assign is_div = op[2];

    // Operand signedness by funct3.
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (op)
            3'd1, 3'd4, 3'd6: begin
                a_sgn = a[XLEN-1];
                b_sgn = b[XLEN-1];
            end
            3'd2: a_sgn = a[XLEN-1];
            default: ;
        endcase
    end

    assign a_mag = a_sgn ? -a : a;
    assign b_mag = b_sgn ? -b : b;

    assign div_zero = is_div && (b == '0);
    assign ovf      = is_div && !op[0]
                    && (a == MIN_NEG) && (b == '1);
    assign special  = div_zero || ovf;

    // op[1] separates REM/REMU from DIV/DIVU.
    always_comb begin
        spec_res = '0;
        if (div_zero)
            spec_res = op[1] ? a : '1;
        else
            spec_res = op[1] ? '0 : a;
    end

    assign last = (cnt == LAST);

    // Multiply step: add multiplicand when low bit set, shift right.
    assign sum    = {1'b0, hi}
                  + (lo[0] ? {1'b0, dvs} : '0);
    assign mul_hi = sum[XLEN:1];
    assign mul_lo = {sum[0], lo[XLEN-1:1]};

    // Divide step: shift in next dividend bit, trial subtract.
    assign diff   = {hi, lo[XLEN-1]} - {1'b0, dvs};
    assign fits   = !diff[XLEN];
    assign div_hi = fits ? diff[XLEN-1:0]
                         : {hi[XLEN-2:0], lo[XLEN-1]};
    assign div_lo = {lo[XLEN-2:0], fits};

    assign prod   = {mul_hi, mul_lo};
    assign prod_s = neg_q ? -prod : prod;
    assign quot   = neg_q ? -div_lo : div_lo;
    assign rem    = neg_r ? -div_hi : div_hi;

    always_comb begin
        fin = '0;
        case (op_q)
            3'd0:             fin = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fin = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       fin = quot;
            default:          fin = rem;
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start_valid)
                    state_n = special ? DONE : CALC;
            end
            CALC: begin
                if (last)
                    state_n = DONE;
            end
            DONE: begin
                if (result_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            dvs   <= '0;
            res_q <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q  <= op;
                cnt   <= '0;
                hi    <= '0;
                lo    <= is_div ? a_mag : b_mag;
                dvs   <= is_div ? b_mag : a_mag;
                neg_q <= a_sgn ^ b_sgn;
                neg_r <= a_sgn;
                if (special)
                    res_q <= spec_res;
            end else if (state == CALC) begin
                hi  <= op_q[2] ? div_hi : mul_hi;
                lo  <= op_q[2] ? div_lo : mul_lo;
                cnt <= last ? '0 : cnt + CW'(1);
                if (last)
                    res_q <= fin;
            end
        end
    end

    assign start_ready  = (state == IDLE);
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);
    assign result       = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed table, random ops vs arithmetic
// model, backpressure and mid-operation reset sequences.
module tb_muldiv_unit;

    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op           (op),
        .a            (a),
        .b            (b),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[15];

    function automatic logic [31:0] model(
        input logic [2:0] o,
        input logic [31:0] x,
        input logic [31:0] y
    );
        longint          sp;
        longint unsigned up;
        logic            ov;
        ov = (x == MIN_NEG) && (y == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin
                up = {32'b0, x} * {32'b0, y};
                return up[31:0];
            end
            3'd1: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return sp[63:32];
            end
            3'd2: begin
                sp = longint'($signed(x)) * longint'({32'b0, y});
                return sp[63:32];
            end
            3'd3: begin
                up = {32'b0, x} * {32'b0, y};
                return up[63:32];
            end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ov) return x;
                return $signed(x) / $signed(y);
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                return x / y;
            end
            3'd6: begin
                if (y == 0) return x;
                if (ov) return 32'd0;
                return $signed(x) % $signed(y);
            end
            default: begin
                if (y == 0) return x;
                return x % y;
            end
        endcase
    endfunction

    function automatic int model_lat(
        input logic [2:0] o,
        input logic [31:0] x,
        input logic [31:0] y
    );
        if (o[2] && (y == 0)) return 0;
        if (o[2] && !o[0] && x == MIN_NEG && y == 32'hFFFF_FFFF)
            return 0;
        return 32;
    endfunction

    task automatic chk(
        input string       nm,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Issue one request; returns the result and the number of edges
    // after the accepting edge until result_valid is seen.
    task automatic run_op(
        input  logic [2:0]  o,
        input  logic [31:0] x,
        input  logic [31:0] y,
        output logic [31:0] r,
        output int          lat
    );
        int g;
        g = 0;
        while (!start_ready && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        op = o;
        a = x;
        b = y;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
        lat = 0;
        while (!result_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result;
    endtask

    task automatic full_op(
        input string       nm,
        input logic [2:0]  o,
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] exp,
        input int          elat
    );
        logic [31:0] r;
        int          lat;
        run_op(o, x, y, r, lat);
        chk({nm, " result"}, r, exp);
        chk({nm, " latency"}, 32'(lat), 32'(elat));
        @(posedge clk); #1;
        chk({nm, " release"}, {30'b0, result_valid, start_ready},
            32'b01);
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
        int          lat;
        int          k;

        tbl[0]  = '{3'd0, 32'd3006, 32'd3005, 32'd9033030, 32};
        tbl[1]  = '{3'd1, MIN_NEG, MIN_NEG, 32'h4000_0000, 32};
        tbl[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'hFFFF_FFFE, 32};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'hFFFF_FFFF, 32};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32};
        tbl[6]  = '{3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32};
        tbl[7]  = '{3'd7, 32'hFFFF_FFF9, 32'd2, 32'd1, 32};
        tbl[8]  = '{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 0};
        tbl[9]  = '{3'd7, 32'd5, 32'd0, 32'd5, 0};
        tbl[10] = '{3'd4, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG, 0};
        tbl[11] = '{3'd6, MIN_NEG, 32'hFFFF_FFFF, 32'd0, 0};
        tbl[12] = '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0};
        tbl[13] = '{3'd6, 32'd5, 32'd0, 32'd5, 0};
        tbl[14] = '{3'd5, 32'd100, 32'd7, 32'd14, 32};

        reset = 1'b1;
        start_valid = 1'b0;
        op = 3'd0;
        a = '0;
        b = '0;
        result_ready = 1'b1;
        #12;
        chk("rst valid", {31'b0, result_valid}, 32'd0);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst ready", {31'b0, start_ready}, 32'd1);
        chk("rst result", result, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 15; i++)
            full_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a,
                    tbl[i].b, tbl[i].exp, tbl[i].lat);

        for (int i = 0; i < 150; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            k = $urandom_range(0, 9);
            if (k == 0) y = '0;
            if (k == 1) begin
                x = MIN_NEG;
                y = 32'hFFFF_FFFF;
            end
            if (k == 2) y = 32'($urandom_range(1, 15));
            full_op($sformatf("rnd%0d op%0d", i, o), o, x, y,
                    model(o, x, y), model_lat(o, x, y));
        end

        result_ready = 1'b0;
        run_op(3'd0, 32'd7, 32'd6, r, lat);
        chk("bp result", r, 32'd42);
        chk("bp latency", 32'(lat), 32'd32);
        for (int i = 0; i < 10; i++) begin
            start_valid = i[0];
            op = 3'd5;
            a = $urandom;
            b = 32'd3;
            @(posedge clk); #1;
            chk("bp hold result", result, 32'd42);
            chk("bp hold flags",
                {29'b0, result_valid, busy, start_ready}, 32'b110);
        end
        start_valid = 1'b0;
        result_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release",
            {29'b0, result_valid, busy, start_ready}, 32'b001);
        @(posedge clk); #1;
        chk("bp no queued op",
            {29'b0, result_valid, busy, start_ready}, 32'b001);

        op = 3'd5;
        a = 32'd100;
        b = 32'd7;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst flags",
            {29'b0, result_valid, busy, start_ready}, 32'b001);
        chk("midrst result", result, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        full_op("post rst divu", 3'd5, 32'd100, 32'd7, 32'd14, 32);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
